// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit FIFO one byte at a time and sends each byte as a UART frame:
// start bit, 8 data bits LSB first, optional even/odd parity, one stop bit.
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nxt;
    logic [7:0]       sreg;
    logic [7:0]       sreg_nxt;
    logic             par_bit;
    logic             par_nxt;
    logic             baud_end;
    logic             tx_nxt;
    logic             rd_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // State, datapath and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sreg    <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            fifo_rd <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            sreg    <= sreg_nxt;
            par_bit <= par_nxt;
            tx      <= tx_nxt;
            fifo_rd <= rd_nxt;
            busy    <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

    // Next-state and next-output decode; outputs are derived from the next state
    // so that each registered output lines up with the state it belongs to.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        bit_nxt   = bit_idx;
        sreg_nxt  = sreg;
        par_nxt   = par_bit;
        baud_end  = (cnt == CNT_MAX);
        tx_nxt    = 1'b1;
        rd_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (enable && !fifo_empty) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                cnt_nxt   = '0;
                state_nxt = S_LOAD;
            end
            S_LOAD: begin
                cnt_nxt   = '0;
                sreg_nxt  = fifo_data;
                par_nxt   = (PARITY == 32'd2) ? ~(^fifo_data) : ^fifo_data;
                state_nxt = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = (PARITY != 32'd0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_nxt  = bit_idx + 3'd1;
                        sreg_nxt = {1'b0, sreg[7:1]};
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    cnt_nxt   = '0;
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = (enable && !fifo_empty) ? S_READ : S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = sreg_nxt[0];
            S_PARITY: tx_nxt = par_nxt;
            default:  tx_nxt = 1'b1;
        endcase

        rd_nxt   = (state_nxt == S_READ);
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) each fed by a
// queue-based FIFO model; a line decoder rebuilds frames from tx alone.
`timescale 1ns/1ps

module tb_fifo_uart_tx;

    localparam int unsigned N = 4;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         start;
        int         done;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] wr = 3'b000;
    logic [7:0] wdata = 8'h00;
    logic       empty0 = 1'b1, empty1 = 1'b1, empty2 = 1'b1;
    logic [7:0] dout0 = 8'h00, dout1 = 8'h00, dout2 = 8'h00;
    logic       rd0, rd1, rd2, tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] tx_v, busy_v, done_v;

    int         cyc = 0;
    int         rst_cnt = 0;
    int         underflow = 0;
    int         wr0_total = 0;
    int         done0_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q0[$], q1[$], q2[$];
    int         rd_log[$];
    frame_t     frames[$];

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) rst_cnt++;

    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty0), .fifo_data(dout0),
        .fifo_rd(rd0), .tx(tx0), .busy(busy0), .tx_done(done0));
    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty1), .fifo_data(dout1),
        .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1));
    fifo_uart_tx #(.CLKS_PER_BIT(N), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty2), .fifo_data(dout2),
        .fifo_rd(rd2), .tx(tx2), .busy(busy2), .tx_done(done2));

    // FIFO models: registered data_out and empty, updated on the pop/push edge
    always @(posedge clk) begin
        if (wr[0]) begin q0.push_back(wdata); wr0_total++; end
        if (wr[1]) q1.push_back(wdata);
        if (wr[2]) q2.push_back(wdata);
        if (rd0) begin if (q0.size() == 0) underflow++; else dout0 <= q0.pop_front(); end
        if (rd1) begin if (q1.size() == 0) underflow++; else dout1 <= q1.pop_front(); end
        if (rd2) begin if (q2.size() == 0) underflow++; else dout2 <= q2.pop_front(); end
        empty0 <= (q0.size() == 0);
        empty1 <= (q1.size() == 0);
        empty2 <= (q2.size() == 0);
    end

    always @(negedge clk) begin
        if (rd0) rd_log.push_back(cyc);
        if (done0) done0_cnt++;
    end

    // Line decoder: samples mid-bit from the falling start edge; frames cut by reset are dropped
    task automatic monitor(input int ln);
        frame_t f;
        int     r0;
        forever begin
            @(negedge clk);
            if (!rst && tx_v[ln] === 1'b0) begin
                f.lane  = ln;
                f.start = cyc;
                r0      = rst_cnt;
                repeat (N / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    f.data[i] = tx_v[ln];
                end
                f.par = 1'b0;
                if (ln != 0) begin
                    repeat (N) @(negedge clk);
                    f.par = tx_v[ln];
                end
                repeat (N) @(negedge clk);
                f.stop = tx_v[ln];
                f.done = -1;
                for (int k = 0; k < 2 * N && f.done < 0; k++) begin
                    @(negedge clk);
                    if (done_v[ln] === 1'b1) f.done = cyc;
                end
                if (rst_cnt == r0) frames.push_back(f);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nframes(input int ln);
        int n = 0;
        foreach (frames[i]) if (frames[i].lane == ln) n++;
        return n;
    endfunction

    task automatic pop_frame(input int ln, output frame_t f);
        f.lane = -1; f.data = 'x; f.par = 1'bx; f.stop = 1'bx; f.start = 0; f.done = -1;
        for (int i = 0; i < frames.size(); i++) begin
            if (frames[i].lane == ln) begin
                f = frames[i];
                frames.delete(i);
                break;
            end
        end
    endtask

    task automatic wait_frames(input int ln, input int n, input int budget);
        int k = 0;
        while (nframes(ln) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("frame_count_lane%0d", ln), 32'(nframes(ln)), 32'(n));
    endtask

    task automatic wait_start0();
        int k = 0;
        while (tx0 !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", 32'(tx0), 32'(0));
    endtask

    task automatic write_byte(input logic [2:0] mask, input logic [7:0] d);
        @(negedge clk);
        wr    = mask;
        wdata = d;
        @(negedge clk);
        wr    = 3'b000;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t     f, g;
        int         base, bad, cw, dbase, k;
        logic [7:0] r;
        logic [7:0] exp_q[$];

        // Reset values, then 50 quiet cycles with the FIFO empty
        rst = 1'b1;
        #100;
        check("reset_tx", 32'(tx_v), 32'(3'b111));
        check("reset_busy", 32'(busy_v), 32'(0));
        check("reset_rd", 32'({rd2, rd1, rd0}), 32'(0));
        check("reset_done", 32'(done_v), 32'(0));
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        bad    = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_v !== 3'b111 || busy_v !== 3'b000 || (rd0 | rd1 | rd2) !== 1'b0) bad++;
        end
        check("idle_50_cycles", 32'(bad), 32'(0));

        // Full drain of 0x01..0x08, no parity
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) write_byte(3'b001, 8'(i));
        @(negedge clk);
        check("fifo_full_level", 32'(q0.size()), 32'(8));
        base   = rd_log.size();
        enable = 1'b1;
        wait_frames(0, 8, 600);
        for (int i = 1; i <= 8; i++) begin
            pop_frame(0, f);
            check($sformatf("drain_data_%0d", i), 32'(f.data), 32'(i));
            check($sformatf("drain_len_%0d", i), 32'(f.done - f.start), 32'(10 * N));
            if (i == 1) check("drain_start_after_rd", 32'(f.start), 32'(rd_log[base] + 2));
        end
        repeat (60) @(negedge clk);
        check("drain_pop_count", 32'(rd_log.size() - base), 32'(8));
        check("drain_empty", 32'(empty0), 32'(1));
        for (int i = 1; i < 8; i++)
            check($sformatf("rd_spacing_%0d", i), 32'(rd_log[base + i] - rd_log[base + i - 1]),
                  32'(10 * N + 2));

        // Random bursts with random gaps
        for (int round = 0; round < 3; round++) begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
                r = 8'($urandom);
                exp_q.push_back(r);
                write_byte(3'b001, r);
            end
            wait_frames(0, k, 1500);
            for (int j = 0; j < k; j++) begin
                pop_frame(0, f);
                r = exp_q.pop_front();
                check("rand_data", 32'(f.data), 32'(r));
                check("rand_stop", 32'(f.stop), 32'(1));
                check("rand_len", 32'(f.done - f.start), 32'(10 * N));
            end
        end

        // Parity: 0x07 then a random byte on the even and odd instances
        for (int j = 0; j < 2; j++) begin
            r = (j == 0) ? 8'h07 : 8'($urandom);
            write_byte(3'b110, r);
            wait_frames(1, 1, 300);
            wait_frames(2, 1, 300);
            pop_frame(1, f);
            pop_frame(2, g);
            check("even_data", 32'(f.data), 32'(r));
            check("even_par", 32'(f.par), 32'(($countones(r) % 2) == 1));
            check("even_len", 32'(f.done - f.start), 32'(11 * N));
            check("odd_data", 32'(g.data), 32'(r));
            check("odd_par", 32'(g.par), 32'(($countones(r) % 2) == 0));
            check("odd_len", 32'(g.done - g.start), 32'(11 * N));
        end

        // Enable dropped during the data bits of the first of three frames
        for (int i = 1; i <= 3; i++) write_byte(3'b001, 8'(8'hC0 + i));
        wait_start0();
        repeat (12) @(negedge clk);
        enable = 1'b0;
        wait_frames(0, 1, 200);
        repeat (80) @(negedge clk);
        check("gate_one_frame", 32'(nframes(0)), 32'(1));
        check("gate_left_in_fifo", 32'(q0.size()), 32'(2));
        check("gate_tx_idle", 32'(tx0), 32'(1));
        check("gate_busy_low", 32'(busy0), 32'(0));
        pop_frame(0, f);
        check("gate_frame1", 32'(f.data), 32'(8'hC1));
        enable = 1'b1;
        wait_frames(0, 2, 300);
        pop_frame(0, f);
        check("gate_frame2", 32'(f.data), 32'(8'hC2));
        pop_frame(0, f);
        check("gate_frame3", 32'(f.data), 32'(8'hC3));

        // Asynchronous reset during bit 3 of 0xA5
        write_byte(3'b001, 8'hA5);
        wait_start0();
        repeat (17) @(negedge clk);
        check("a5_bit3_low", 32'(tx0), 32'(0));
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx0), 32'(1));
        check("async_rst_busy", 32'(busy0), 32'(0));
        check("async_rst_rd", 32'(rd0), 32'(0));
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        base = rd_log.size();
        repeat (60) @(negedge clk);
        check("post_rst_no_frame", 32'(nframes(0)), 32'(0));
        check("post_rst_no_pop", 32'(rd_log.size()), 32'(base));
        write_byte(3'b001, 8'h3C);
        wait_frames(0, 1, 200);
        pop_frame(0, f);
        check("post_rst_3c", 32'(f.data), 32'(8'h3C));

        // Late write while idle: pop, start and done timing
        repeat (10) @(negedge clk);
        base  = rd_log.size();
        dbase = done0_cnt;
        r     = 8'($urandom);
        @(negedge clk);
        cw    = cyc;
        wr    = 3'b001;
        wdata = r;
        @(negedge clk);
        wr    = 3'b000;
        wait_frames(0, 1, 200);
        pop_frame(0, f);
        repeat (10) @(negedge clk);
        check("late_one_pop", 32'(rd_log.size()), 32'(base + 1));
        check("late_rd_cycle", 32'(rd_log[base]), 32'(cw + 2));
        check("late_start_cycle", 32'(f.start), 32'(cw + 4));
        check("late_done_cycle", 32'(f.done), 32'(f.start + 10 * N));
        check("late_done_once", 32'(done0_cnt - dbase), 32'(1));
        check("late_data", 32'(f.data), 32'(r));

        // Global bookkeeping
        check("no_underflow", 32'(underflow), 32'(0));
        check("pops_equal_writes", 32'(rd_log.size()), 32'(wr0_total));
        check("done_per_complete_frame", 32'(done0_cnt), 32'(rd_log.size() - 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
